seg_scan_display: RTL and testbench
===================================

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 Parameter NUM_DIGITS, 4: digit count, 2..16.
REQ-002 Parameter SLOT_W, 10: one digit slot lasts 2**SLOT_W clk cycles; SLOT_W >= 4.
REQ-003 Parameter BLINK_FRAMES, 64: full scan frames per blink half-period, >= 1.
REQ-004 Parameter SEG_ACT_LOW, 0: 1 inverts seg output polarity.
REQ-005 Parameter WAY_ACT_LOW, 0: 1 inverts way output polarity.
REQ-006 clk  in  1  sole clock; all state on posedge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 wr_en  in  1  write strobe for digit register file.
REQ-009 wr_addr  in  AW=$clog2(NUM_DIGITS)  digit index, 0 = rightmost.
REQ-010 wr_data  in  4  hex value 0-F.
REQ-011 wr_dp  in  1  decimal point for addressed digit.
REQ-012 wr_blank  in  1  force addressed digit dark.
REQ-013 lz_suppress  in  1  leading-zero suppression enable.
REQ-014 blink_mask  in  NUM_DIGITS  per-digit blink enable.
REQ-015 brightness  in  4  duty level, 0 = off, 15 = max.
REQ-016 seg  out  8  registered segments {a,b,c,d,e,f,g,dp}, bit7 = a, bit0 = dp.
REQ-017 way  out  NUM_DIGITS  registered one-hot digit enable, bit i = digit i.
REQ-018 frame_tick  out  1  one-cycle pulse at each scan-frame wrap.

Function
REQ-019 Slot counter cnt (SLOT_W bits) SHALL increment every cycle and wrap to 0; on wrap, scan index idx SHALL advance, NUM_DIGITS-1 -> 0.
REQ-020 frame_tick SHALL be 1 for exactly the cycle after idx wraps NUM_DIGITS-1 -> 0.
REQ-021 Writes with wr_en=1 SHALL update value/dp/blank of digit wr_addr at the clock edge; wr_addr >= NUM_DIGITS SHALL be ignored.
REQ-022 Hex encoding (active-high, a..g): 0=FC 1=60 2=DA 3=F2 4=66 5=B6 6=BE 7=E0 8=FE 9=E6 A=EE b=3E C=9C d=7A E=9E F=8E; dp ORs into bit0.
REQ-023 Let top = cnt[SLOT_W-1:SLOT_W-4]; segments lit only when top != 0 and top <= brightness (top = 0 is the anti-ghost guard; max duty 15/16).
REQ-024 Blink phase SHALL toggle every BLINK_FRAMES frame wraps; while phase = 1, digits with blink_mask bit set SHALL be dark.
REQ-025 With lz_suppress=1, digit i (i >= 1) SHALL be dark if it and all higher digits have value 0, dp 0, blank 0; digit 0 is never suppressed.
REQ-026 A dark digit drives seg all-off; way still selects idx.
REQ-027 seg/way SHALL be registered: one-cycle latency from cnt/idx/register state; writes to the shown digit SHALL appear on the next cycle's outputs.
REQ-028 way SHALL be exactly one-hot (pre-polarity) at all times after the first post-reset cycle; never two digits enabled.
REQ-029 Polarity parameters SHALL apply only at the output registers.

Reset
REQ-030 On rst_n=0, asynchronously: cnt=0, idx=0, blink phase=0, frame counter=0, all digit values=0, dp=0, blank=1.
REQ-031 In reset, seg SHALL be all-off, way all-off (polarity-adjusted), frame_tick=0.
REQ-032 Reset asserted mid-slot SHALL abort the scan; after release, scanning restarts at digit 0, cnt 0.

Structure
REQ-033 Package seg_pkg SHALL hold the 16-entry hex-to-segment constant table and segment bit-position constants.
REQ-034 Sub-module seg_hex_decode (4-bit value + dp -> 8-bit active-high pattern) SHALL be instantiated once on the scan path.

Verification
REQ-035 NUM_DIGITS=4, SLOT_W=4, brightness=15, write 1,2,3,4 to digits 0..3 -> way cycles 0001,0010,0100,1000 every 16 cycles; digit 2 shows F2 when lit.
REQ-036 brightness=0 -> seg all-off always; brightness=1 -> lit only while top==1 (1 cycle of 16 at SLOT_W=4).
REQ-037 Values 0,0,5,0 on digits 3..0, lz_suppress=1 -> digits 3,2 dark, digit 1 B6, digit 0 FC; lz_suppress=0 -> digit 3 FC.
REQ-038 blink_mask=0001, BLINK_FRAMES=2 -> digit 0 lit 2 frames, dark 2 frames, repeating; frame_tick once per 64 cycles.
REQ-039 Assert rst_n low mid-slot of digit 2 -> outputs off immediately; after release way=0001 after one cycle, all digits blank until written.
REQ-040 SEG_ACT_LOW=1, WAY_ACT_LOW=1, digit 0 = 8 with dp -> seg=00, way=1110 while digit 0 lit.

Source files
------------

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared constants and types for the multiplexed seven-segment
//               scanner: hex-to-segment table, segment bit positions, the
//               per-digit register record and the blink phase encoding.
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package seg_pkg;

    // Segment bit positions inside the 8-bit pattern {a,b,c,d,e,f,g,dp}.
    localparam int SEG_A_BIT  = 7;
    localparam int SEG_B_BIT  = 6;
    localparam int SEG_C_BIT  = 5;
    localparam int SEG_D_BIT  = 4;
    localparam int SEG_E_BIT  = 3;
    localparam int SEG_F_BIT  = 2;
    localparam int SEG_G_BIT  = 1;
    localparam int SEG_DP_BIT = 0;

    localparam logic [7:0] SEG_ALL_OFF = 8'h00;

    // Active-high a..g patterns, entry n occupies bits [8n+7:8n].
    // Listed from F (most significant) down to 0.
    localparam logic [127:0] HEX_SEG_TABLE = {
        8'h8E, 8'h9E, 8'h7A, 8'h9C,   // F E d C
        8'h3E, 8'hEE, 8'hE6, 8'hFE,   // b A 9 8
        8'hE0, 8'hBE, 8'hB6, 8'h66,   // 7 6 5 4
        8'hF2, 8'hDA, 8'h60, 8'hFC    // 3 2 1 0
    };

    // Blink phase: HIDE darkens every digit whose blink_mask bit is set.
    typedef enum logic {
        BLINK_SHOW = 1'b0,
        BLINK_HIDE = 1'b1
    } blink_phase_e;

    // One entry of the digit register file.
    typedef struct packed {
        logic [3:0] value;
        logic       dp;
        logic       blank;
    } digit_t;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] value);
        return HEX_SEG_TABLE[{value, 3'b000} +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_hex_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg_hex_decode
// Description : Combinational hex digit to active-high segment pattern.
// Ports       : value   in  4  hex value 0-F
//               dp      in  1  decimal point, ORed into bit 0
//               pattern out 8  {a,b,c,d,e,f,g,dp}, active high
// Revision    : 1.0  initial release
// ============================================================================
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] value,
    input  logic       dp,
    output logic [7:0] pattern
);

    always_comb begin
        pattern             = hex_to_seg(value);
        pattern[SEG_DP_BIT] = pattern[SEG_DP_BIT] | dp;
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_display
// Description : Time-multiplexed seven-segment display scanner with a digit
//               register file, PWM brightness, per-digit blinking and
//               leading-zero suppression.
// Ports       : clk          in   1     clock, all state on posedge
//               rst_n        in   1     asynchronous active-low reset
//               wr_en        in   1     digit register write strobe
//               wr_addr      in   AW    digit index, 0 = rightmost
//               wr_data      in   4     hex value
//               wr_dp        in   1     decimal point of addressed digit
//               wr_blank     in   1     force addressed digit dark
//               lz_suppress  in   1     leading-zero suppression enable
//               blink_mask   in   N     per-digit blink enable
//               brightness   in   4     duty level 0 (off) .. 15 (max)
//               seg          out  8     registered segments {a..g,dp}
//               way          out  N     registered one-hot digit enable
//               frame_tick   out  1     pulse at each scan-frame wrap
// Revision    : 1.0  initial release
// ============================================================================
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_W       = 10,
    parameter int BLINK_FRAMES = 64,
    parameter bit SEG_ACT_LOW  = 1'b0,
    parameter bit WAY_ACT_LOW  = 1'b0,
    localparam int AW          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [3:0]            wr_data,
    input  logic                  wr_dp,
    input  logic                  wr_blank,
    input  logic                  lz_suppress,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    input  logic [3:0]            brightness,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] way,
    output logic                  frame_tick
);

    localparam int                    FW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [AW-1:0]         IDX_LAST   = AW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0]         FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [7:0]            SEG_POL    = {8{SEG_ACT_LOW}};
    localparam logic [NUM_DIGITS-1:0] WAY_POL    = {NUM_DIGITS{WAY_ACT_LOW}};
    localparam digit_t                DIGIT_RST  = '{value: 4'h0, dp: 1'b0, blank: 1'b1};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SLOT_W-1:0]     cnt_q,        cnt_d;
    logic [AW-1:0]         idx_q,        idx_d;
    logic [FW-1:0]         frame_cnt_q,  frame_cnt_d;
    blink_phase_e          blink_q,      blink_d;
    digit_t                digit_q [NUM_DIGITS];
    digit_t                digit_d [NUM_DIGITS];
    logic [7:0]            seg_q,        seg_d;
    logic [NUM_DIGITS-1:0] way_q,        way_d;
    logic                  frame_tick_q, frame_tick_d;

    // ------------------------------------------------------------------
    // Scan timing: slot counter, digit index, frame and blink counters
    // ------------------------------------------------------------------
    logic cnt_wrap;
    logic frame_wrap;

    always_comb begin
        cnt_wrap     = &cnt_q;
        frame_wrap   = cnt_wrap && (idx_q == IDX_LAST);

        cnt_d        = cnt_q + SLOT_W'(1);
        idx_d        = idx_q;
        frame_cnt_d  = frame_cnt_q;
        blink_d      = blink_q;
        frame_tick_d = frame_wrap;

        if (cnt_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + AW'(1);
        end

        if (frame_wrap) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d = '0;
                blink_d     = (blink_q == BLINK_SHOW) ? BLINK_HIDE : BLINK_SHOW;
            end else begin
                frame_cnt_d = frame_cnt_q + FW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit register file
    // ------------------------------------------------------------------
    logic addr_ok;

    always_comb begin
        // Out-of-range addresses only exist when NUM_DIGITS is not a power of two.
        addr_ok = (32'(wr_addr) < NUM_DIGITS);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_d[i] = digit_q[i];
            if (wr_en && addr_ok && (32'(wr_addr) == i)) begin
                digit_d[i] = '{value: wr_data, dp: wr_dp, blank: wr_blank};
            end
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero detection: a digit qualifies when it and every digit
    // to its left hold value 0 with no dp and no blank. Digit 0 always shows.
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] lz_dark;

    always_comb begin
        logic zero_run;
        lz_dark  = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (digit_q[i].value == 4'h0) &&
                       !digit_q[i].dp && !digit_q[i].blank;
            if (i != 0) begin
                lz_dark[i] = zero_run;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan path: pick the current digit, decode, gate, apply polarity
    // ------------------------------------------------------------------
    digit_t     cur_digit;
    logic [7:0] hex_pattern;
    logic [3:0] duty_top;
    logic       duty_on;
    logic       dark;

    assign cur_digit = digit_q[idx_q];

    seg_hex_decode u_hex_decode (
        .value   (cur_digit.value),
        .dp      (cur_digit.dp),
        .pattern (hex_pattern)
    );

    always_comb begin
        duty_top = cnt_q[SLOT_W-1 -: 4];
        // top == 0 keeps every slot dark for its first sixteenth so the
        // previous digit's segments cannot ghost onto the newly enabled one.
        duty_on  = (duty_top != 4'd0) && (duty_top <= brightness);

        dark = !duty_on
            || cur_digit.blank
            || (lz_suppress && lz_dark[idx_q])
            || ((blink_q == BLINK_HIDE) && blink_mask[idx_q]);

        // Polarity is folded in only at the register input.
        seg_d = (dark ? SEG_ALL_OFF : hex_pattern) ^ SEG_POL;
        way_d = (NUM_DIGITS'(1) << idx_q) ^ WAY_POL;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            frame_cnt_q  <= '0;
            blink_q      <= BLINK_SHOW;
            seg_q        <= SEG_ALL_OFF ^ SEG_POL;
            way_q        <= WAY_POL;
            frame_tick_q <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= DIGIT_RST;
            end
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_q      <= blink_d;
            seg_q        <= seg_d;
            way_q        <= way_d;
            frame_tick_q <= frame_tick_d;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= digit_d[i];
            end
        end
    end

    assign seg        = seg_q;
    assign way        = way_q;
    assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_display
// Description : Scoreboard bench for seg_scan_display. The stimulus process
//               queues hand-computed expectations tagged with the clock cycle
//               they are due; a monitor samples the outputs on every falling
//               edge and compares against the head of the queue.
//               Scan time s = cycles since reset release; the outputs seen
//               after the (s+1)-th rising edge reflect scan state s.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seg_scan_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_dp;
    logic       wr_blank;
    logic       lz_suppress;
    logic [3:0] blink_mask;
    logic [3:0] brightness;

    logic [7:0] seg,   seg_n;
    logic [3:0] way,   way_n;
    logic       frame_tick, frame_tick_n;

    always #5 clk = ~clk;

    seg_scan_display #(
        .NUM_DIGITS   (4),
        .SLOT_W       (4),
        .BLINK_FRAMES (2),
        .SEG_ACT_LOW  (1'b0),
        .WAY_ACT_LOW  (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_dp       (wr_dp),
        .wr_blank    (wr_blank),
        .lz_suppress (lz_suppress),
        .blink_mask  (blink_mask),
        .brightness  (brightness),
        .seg         (seg),
        .way         (way),
        .frame_tick  (frame_tick)
    );

    // Same stimulus, inverted output polarity.
    seg_scan_display #(
        .NUM_DIGITS   (4),
        .SLOT_W       (4),
        .BLINK_FRAMES (2),
        .SEG_ACT_LOW  (1'b1),
        .WAY_ACT_LOW  (1'b1)
    ) dut_n (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_dp       (wr_dp),
        .wr_blank    (wr_blank),
        .lz_suppress (lz_suppress),
        .blink_mask  (blink_mask),
        .brightness  (brightness),
        .seg         (seg_n),
        .way         (way_n),
        .frame_tick  (frame_tick_n)
    );

    typedef struct {
        int         target;
        string      name;
        logic [7:0] seg;
        logic [3:0] way;
        logic       tick;
        bit         inv;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   base = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   stim_done = 1'b0;
    bit   mon_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Stimulus helpers (called at a falling edge)
    // ------------------------------------------------------------------
    task automatic exp_at(input int target, input string name, input logic [7:0] s,
                          input logic [3:0] w, input logic t, input bit inv);
        exp_t e;
        e.target = target; e.name = name; e.seg = s; e.way = w; e.tick = t; e.inv = inv;
        exp_q.push_back(e);
    endtask

    task automatic exp_s(input int s0, input string name, input logic [7:0] s,
                         input logic [3:0] w, input logic t, input bit inv);
        exp_at(base + s0 + 1, name, s, w, t, inv);
    endtask

    task automatic goto_s(input int s0);
        while (cyc < base + s0) @(negedge clk);
    endtask

    task automatic wr(input int a, input int v, input bit dp, input bit blank);
        wr_en    = 1'b1;
        wr_addr  = 2'(a);
        wr_data  = 4'(v);
        wr_dp    = dp;
        wr_blank = blank;
        @(negedge clk);
        wr_en    = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        int   drain = 0;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].target <= cyc) begin
                e = exp_q.pop_front();
                n_tests++;
                if (e.target < cyc) begin
                    n_fail++;
                    $display("FAIL %s: check missed, due cycle %0d, now %0d", e.name, e.target, cyc);
                end else if (seg !== e.seg || way !== e.way || frame_tick !== e.tick) begin
                    n_fail++;
                    $display("FAIL %s: got seg=%02h way=%04b tick=%0b, expected seg=%02h way=%04b tick=%0b",
                             e.name, seg, way, frame_tick, e.seg, e.way, e.tick);
                end
                if (e.inv && e.target == cyc) begin
                    n_tests++;
                    if (seg_n !== ~e.seg || way_n !== ~e.way) begin
                        n_fail++;
                        $display("FAIL %s_inv: got seg=%02h way=%04b, expected seg=%02h way=%04b",
                                 e.name, seg_n, way_n, ~e.seg, ~e.way);
                    end
                end
            end
            if (stim_done && !mon_done) begin
                if (exp_q.size() == 0) begin
                    mon_done = 1'b1;
                end else begin
                    drain++;
                    if (drain > 200) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL drain: %0d checks never reached, expected 0", exp_q.size());
                        mon_done = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        rst_n       = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        wr_dp       = 1'b0;
        wr_blank    = 1'b0;
        lz_suppress = 1'b0;
        blink_mask  = 4'b0000;
        brightness  = 4'd15;

        repeat (3) @(negedge clk);
        exp_at(cyc + 1, "reset", 8'h00, 4'b0000, 1'b0, 1'b1);
        repeat (2) @(negedge clk);

        base  = cyc;
        rst_n = 1'b1;
        exp_s(0, "rst_release", 8'h00, 4'b0001, 1'b0, 1'b0);
        wr(0, 1, 0, 0);
        wr(1, 2, 0, 0);
        wr(2, 3, 0, 0);
        wr(3, 4, 0, 0);
        exp_s(17, "d1_two",     8'hDA, 4'b0010, 1'b0, 1'b0);
        exp_s(32, "slot_guard", 8'h00, 4'b0100, 1'b0, 1'b0);
        exp_s(37, "d2_three",   8'hF2, 4'b0100, 1'b0, 1'b0);
        exp_s(62, "pre_tick",   8'h66, 4'b1000, 1'b0, 1'b0);
        exp_s(63, "frame_tick", 8'h66, 4'b1000, 1'b1, 1'b0);
        exp_s(64, "tick_end",   8'h00, 4'b0001, 1'b0, 1'b0);
        exp_s(65, "d0_one",     8'h60, 4'b0001, 1'b0, 1'b0);

        goto_s(80);
        brightness = 4'd1;
        exp_s(81, "bright1_on",  8'hDA, 4'b0010, 1'b0, 1'b0);
        exp_s(82, "bright1_off", 8'h00, 4'b0010, 1'b0, 1'b0);
        goto_s(96);
        brightness = 4'd0;
        exp_s(97,  "bright0_a", 8'h00, 4'b0100, 1'b0, 1'b0);
        exp_s(111, "bright0_b", 8'h00, 4'b0100, 1'b0, 1'b0);
        goto_s(112);
        brightness = 4'd15;

        goto_s(113);
        wr(3, 0, 0, 0);
        wr(2, 0, 0, 0);
        wr(1, 5, 0, 0);
        wr(0, 0, 0, 0);
        lz_suppress = 1'b1;
        exp_s(129, "lz_d0", 8'hFC, 4'b0001, 1'b0, 1'b0);
        exp_s(145, "lz_d1", 8'hB6, 4'b0010, 1'b0, 1'b0);
        exp_s(161, "lz_d2", 8'h00, 4'b0100, 1'b0, 1'b0);
        exp_s(177, "lz_d3", 8'h00, 4'b1000, 1'b0, 1'b0);
        goto_s(180);
        lz_suppress = 1'b0;
        exp_s(181, "lz_off_d3", 8'hFC, 4'b1000, 1'b0, 1'b0);

        goto_s(190);
        blink_mask = 4'b0001;
        exp_s(193, "blink_dark", 8'h00, 4'b0001, 1'b0, 1'b0);
        exp_s(255, "tick2",      8'hFC, 4'b1000, 1'b1, 1'b0);
        exp_s(257, "blink_lit",  8'hFC, 4'b0001, 1'b0, 1'b0);
        exp_s(260, "pre_write",  8'hFC, 4'b0001, 1'b0, 1'b0);
        goto_s(260);
        wr(0, 8, 1, 0);
        exp_s(261, "write_next", 8'hFF, 4'b0001, 1'b0, 1'b1);
        wr(1, 5, 0, 1);
        exp_s(273, "blanked",     8'h00, 4'b0010, 1'b0, 1'b0);
        exp_s(319, "tick3",       8'hFC, 4'b1000, 1'b1, 1'b0);
        exp_s(385, "blink_dark2", 8'h00, 4'b0001, 1'b0, 1'b0);
        goto_s(386);
        blink_mask = 4'b0000;

        // Reset in the middle of digit 2's slot.
        goto_s(423);
        exp_at(cyc + 1, "rst_mid", 8'h00, 4'b0000, 1'b0, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        base  = cyc;
        rst_n = 1'b1;
        exp_s(0,  "rst2_way",    8'h00, 4'b0001, 1'b0, 1'b0);
        exp_s(1,  "rst2_blank0", 8'h00, 4'b0001, 1'b0, 1'b0);
        exp_s(17, "rst2_blank1", 8'h00, 4'b0010, 1'b0, 1'b0);
        goto_s(20);
        wr(2, 10, 0, 0);
        exp_s(33, "rst2_d2_A", 8'hEE, 4'b0100, 1'b0, 1'b0);
        exp_s(49, "rst2_d3",   8'h00, 4'b1000, 1'b0, 1'b0);

        stim_done = 1'b1;
        wait (mon_done);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
